// File: rtl/pd_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : pd_tx_framer
//  Purpose  : Transmit framer. Wraps 64 B payload beats with STP/SDP and END,
//             pad-fills the END word and emits logical idle between packets.
//  Revision : 1.0  initial release
// ============================================================================
module pd_tx_framer #(
    parameter logic [7:0] STP_SYM = 8'hFB,
    parameter logic [7:0] SDP_SYM = 8'h5C,
    parameter logic [7:0] END_SYM = 8'hFD,
    parameter logic [7:0] PAD_SYM = 8'hF7,
    parameter logic [7:0] IDL_SYM = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] pkt_data,
    input  logic         pkt_valid,
    output logic         pkt_ready,
    input  logic         pkt_sop,
    input  logic         pkt_eop,
    input  logic         pkt_type,
    input  logic [6:0]   pkt_bytes,
    input  logic         hld_in,
    output logic [511:0] data_out,
    output logic [63:0]  DK_out,
    output logic         out_valid,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [7:0]   r_carry;
    logic [7:0]   w_carry_nxt;
    logic         r_flush_carry;
    logic         w_flush_carry_nxt;
    logic [511:0] r_data;
    logic [511:0] w_data_nxt;
    logic [63:0]  r_dk;
    logic [63:0]  w_dk_nxt;
    logic         r_valid;
    logic         w_valid_nxt;
    logic         r_err;
    logic         w_err_nxt;

    logic         w_ready;
    logic         w_accept;
    logic         w_take;
    logic [6:0]   w_nbytes;
    logic [7:0]   w_lane0_sym;
    logic         w_lane0_k;
    logic [511:0] w_shift_data;
    logic [63:0]  w_shift_dk;
    logic [511:0] w_term_data;
    logic [63:0]  w_term_dk;
    logic [511:0] w_flush_data;
    logic [63:0]  w_flush_dk;

    assign w_ready   = rst & ~hld_in & (r_state != S_FLUSH);
    assign w_accept  = pkt_valid & w_ready;
    // A non-sop beat in IDLE is dropped; everything else is framed.
    assign w_take    = w_accept & (pkt_sop | (r_state == S_DATA));
    assign pkt_ready = w_ready;

    assign w_nbytes    = ((pkt_bytes == 7'd0) || (pkt_bytes > 7'd64)) ? 7'd64 : pkt_bytes;
    assign w_lane0_sym = (r_state == S_IDLE) ? (pkt_type ? SDP_SYM : STP_SYM) : r_carry;
    assign w_lane0_k   = (r_state == S_IDLE);

    // Payload shifts up one lane; the byte falling off the top becomes next word's lane 0.
    assign w_shift_data = {pkt_data[503:0], w_lane0_sym};
    assign w_shift_dk   = {63'd0, w_lane0_k};

    always_comb begin
        w_term_data = w_shift_data;
        w_term_dk   = w_shift_dk;
        for (int i = 1; i < 64; i++) begin
            if (7'(i) == w_nbytes + 7'd1) begin
                w_term_data[8*i +: 8] = END_SYM;
                w_term_dk[i]          = 1'b1;
            end else if (7'(i) > w_nbytes) begin
                w_term_data[8*i +: 8] = PAD_SYM;
                w_term_dk[i]          = 1'b1;
            end
        end
    end

    always_comb begin
        w_flush_data = {64{PAD_SYM}};
        w_flush_dk   = '1;
        if (r_flush_carry) begin
            w_flush_data[7:0]  = r_carry;
            w_flush_data[15:8] = END_SYM;
            w_flush_dk[0]      = 1'b0;
        end else begin
            w_flush_data[7:0]  = END_SYM;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_carry_nxt       = r_carry;
        w_flush_carry_nxt = r_flush_carry;
        w_data_nxt        = '0;
        w_dk_nxt          = '0;
        w_valid_nxt       = 1'b0;
        w_err_nxt         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_data_nxt  = {64{IDL_SYM}};
                w_valid_nxt = 1'b1;
                w_err_nxt   = w_accept & ~pkt_sop;
            end
            S_DATA: begin
                w_err_nxt = w_accept & pkt_sop;
            end
            S_FLUSH: begin
                w_data_nxt  = w_flush_data;
                w_dk_nxt    = w_flush_dk;
                w_valid_nxt = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_take) begin
            w_valid_nxt = 1'b1;
            w_carry_nxt = pkt_data[511:504];
            if (!pkt_eop) begin
                w_data_nxt  = w_shift_data;
                w_dk_nxt    = w_shift_dk;
                w_state_nxt = S_DATA;
            end else if (w_nbytes <= 7'd62) begin
                w_data_nxt  = w_term_data;
                w_dk_nxt    = w_term_dk;
                w_state_nxt = S_IDLE;
            end else begin
                // END does not fit in this word; it goes out in the FLUSH word.
                w_data_nxt        = w_shift_data;
                w_dk_nxt          = w_shift_dk;
                w_state_nxt       = S_FLUSH;
                w_flush_carry_nxt = (w_nbytes == 7'd64);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_carry       <= 8'd0;
            r_flush_carry <= 1'b0;
            r_data        <= '0;
            r_dk          <= '0;
            r_valid       <= 1'b0;
            r_err         <= 1'b0;
        end else if (!hld_in) begin
            r_state       <= w_state_nxt;
            r_carry       <= w_carry_nxt;
            r_flush_carry <= w_flush_carry_nxt;
            r_data        <= w_data_nxt;
            r_dk          <= w_dk_nxt;
            r_valid       <= w_valid_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign data_out  = r_data;
    assign DK_out    = r_dk;
    assign out_valid = r_valid;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pd_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pd_tx_framer
//  Purpose  : Directed bench for pd_tx_framer with a lane-stream reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pd_tx_framer;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] pkt_data;
    logic         pkt_valid;
    logic         pkt_ready;
    logic         pkt_sop;
    logic         pkt_eop;
    logic         pkt_type;
    logic [6:0]   pkt_bytes;
    logic         hld_in;
    logic [511:0] data_out;
    logic [63:0]  DK_out;
    logic         out_valid;
    logic         err;

    always #5 clk = ~clk;

    pd_tx_framer dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_sop   (pkt_sop),
        .pkt_eop   (pkt_eop),
        .pkt_type  (pkt_type),
        .pkt_bytes (pkt_bytes),
        .hld_in    (hld_in),
        .data_out  (data_out),
        .DK_out    (DK_out),
        .out_valid (out_valid),
        .err       (err)
    );

    // Model: a flat stream of lanes {K, byte}; each output word pops 64 lanes.
    logic [8:0]   mq[$];
    bit           m_in_pkt;
    logic [511:0] e_data;
    logic [63:0]  e_dk;
    logic         e_valid;
    logic         e_err;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] ramp(input logic [7:0] base);
        logic [511:0] r;
        for (int b = 0; b < 64; b++) r[8*b +: 8] = base + 8'(b);
        return r;
    endfunction

    task automatic drive(input logic v, input logic s, input logic e, input logic t,
                         input logic [6:0] n, input logic [511:0] d);
        pkt_valid = v; pkt_sop = s; pkt_eop = e; pkt_type = t; pkt_bytes = n; pkt_data = d;
    endtask

    task automatic model_step();
        int n;
        logic [8:0] s;
        bit acc;
        if (!rst) begin
            mq.delete();
            m_in_pkt = 0;
            e_data = '0; e_dk = '0; e_valid = 0; e_err = 0;
            return;
        end
        if (hld_in) return;
        e_err = 0;
        acc = pkt_valid && (mq.size() < 64);
        if (acc) begin
            if (!m_in_pkt && !pkt_sop) begin
                e_err = 1;
            end else begin
                if (m_in_pkt && pkt_sop) e_err = 1;
                if (!m_in_pkt) mq.push_back({1'b1, pkt_type ? 8'h5C : 8'hFB});
                n = 64;
                if (pkt_eop && pkt_bytes != 0 && pkt_bytes <= 64) n = int'(pkt_bytes);
                for (int b = 0; b < n; b++) mq.push_back({1'b0, pkt_data[8*b +: 8]});
                if (pkt_eop) begin
                    mq.push_back({1'b1, 8'hFD});
                    while (mq.size() % 64 != 0) mq.push_back({1'b1, 8'hF7});
                    m_in_pkt = 0;
                end else begin
                    m_in_pkt = 1;
                end
            end
        end
        if (mq.size() >= 64) begin
            for (int l = 0; l < 64; l++) begin
                s = mq.pop_front();
                e_data[8*l +: 8] = s[7:0];
                e_dk[l] = s[8];
            end
            e_valid = 1;
        end else if (!m_in_pkt && mq.size() == 0) begin
            e_data = '0; e_dk = '0; e_valid = 1;
        end else begin
            e_valid = 0;
        end
    endtask

    task automatic tick();
        #1;
        chk("pkt_ready", pkt_ready, (rst && !hld_in && mq.size() < 64));
        model_step();
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, e_valid);
        chk("err", err, e_err);
        if (e_valid) begin
            chk("data_out", data_out, e_data);
            chk("DK_out", DK_out, e_dk);
        end
    endtask

    logic [511:0] flush63;

    initial begin
        rst = 1'b0;
        hld_in = 1'b0;
        drive(1, 1, 0, 0, 7'd0, ramp(8'h00));

        // Reset with a beat offered
        repeat (3) tick();
        chk("rst_data", data_out, 512'd0);
        chk("rst_dk", DK_out, 64'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", pkt_ready, 1'b0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 7'd0, '0);
        tick();
        chk("idle_valid", out_valid, 1'b1);
        chk("idle_data", data_out, 512'd0);

        // Single-beat DLLP, 8 bytes
        drive(1, 1, 1, 1, 7'd8, ramp(8'h01));
        tick();
        chk("dllp_dk", DK_out, 64'hFFFF_FFFF_FFFF_FE01);
        chk("dllp_l0", data_out[7:0], 8'h5C);
        chk("dllp_pay", data_out[71:8], 64'h0807_0605_0403_0201);
        chk("dllp_end", data_out[79:72], 8'hFD);
        chk("dllp_pad", data_out[87:80], 8'hF7);

        // 3-beat TLP ending with 64 bytes
        drive(1, 1, 0, 0, 7'd0, ramp(8'h10)); tick();
        drive(1, 0, 0, 0, 7'd0, ramp(8'h50)); tick();
        drive(1, 0, 1, 0, 7'd64, ramp(8'h90)); tick();
        drive(0, 0, 0, 0, 7'd0, '0);
        #1;
        chk("flush_ready", pkt_ready, 1'b0);
        tick();
        chk("f64_l0", data_out[7:0], 8'hCF);
        chk("f64_l1", data_out[15:8], 8'hFD);
        chk("f64_dk01", DK_out[1:0], 2'b10);

        // Two-beat TLP ending with 63 bytes; next packet waits through FLUSH
        drive(1, 1, 0, 0, 7'd0, ramp(8'h20)); tick();
        drive(1, 0, 1, 0, 7'd63, ramp(8'h60)); tick();
        drive(1, 1, 1, 0, 7'd1, ramp(8'hA0)); tick();
        flush63 = {{63{8'hF7}}, 8'hFD};
        chk("f63_data", data_out, flush63);
        chk("f63_dk", DK_out, {64{1'b1}});
        tick();

        // END lands in lane 63, then a back-to-back full beat (bytes=0 means 64)
        drive(1, 1, 1, 0, 7'd62, ramp(8'h30)); tick();
        chk("n62_end", data_out[511:504], 8'hFD);
        drive(1, 1, 1, 1, 7'd0, ramp(8'h70)); tick();
        drive(0, 0, 0, 0, 7'd0, '0); tick();
        tick();

        // Hold for 4 cycles mid-packet
        drive(1, 1, 0, 0, 7'd0, ramp(8'h40)); tick();
        hld_in = 1'b1;
        drive(1, 0, 0, 0, 7'd0, ramp(8'h80));
        repeat (4) tick();
        chk("hold_ready", pkt_ready, 1'b0);
        hld_in = 1'b0;
        tick();
        drive(1, 0, 1, 0, 7'd10, ramp(8'hC0)); tick();
        drive(0, 0, 0, 0, 7'd0, '0); tick();

        // Non-sop beat while idle
        drive(1, 0, 1, 0, 7'd4, ramp(8'hE0)); tick();
        chk("nosop_err", err, 1'b1);
        chk("nosop_data", data_out, 512'd0);
        chk("nosop_dk", DK_out, 64'd0);
        drive(0, 0, 0, 0, 7'd0, '0); tick();
        chk("nosop_err_clr", err, 1'b0);

        // Sop inside a packet, then a bubble
        drive(1, 1, 0, 1, 7'd0, ramp(8'h05)); tick();
        drive(1, 1, 0, 0, 7'd0, ramp(8'h45)); tick();
        drive(0, 0, 0, 0, 7'd0, '0); tick();
        chk("bubble_valid", out_valid, 1'b0);
        drive(1, 0, 1, 0, 7'd20, ramp(8'h85)); tick();
        drive(0, 0, 0, 0, 7'd0, '0); tick();

        // Reset in mid-packet discards it
        drive(1, 1, 0, 0, 7'd0, ramp(8'h15)); tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 7'd0, '0); tick();
        rst = 1'b1;
        tick();
        chk("post_rst_idle", data_out, 512'd0);
        drive(1, 1, 1, 0, 7'd3, ramp(8'h55)); tick();
        drive(0, 0, 0, 0, 7'd0, '0); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
